// File: rtl/iz_pkg.sv
// -----------------------------------------------------------------------------
// iz_pkg
// Shared definitions for the time-multiplexed Izhikevich neuron array:
//   - fixed-point scale constants (threshold, rest, the 140 term) as functions
//     of the fraction width, so every module scales consistently
//   - cfg_sel field encodings
//   - step FSM state enum
//   - saturate(): clamps a wide signed intermediate into a narrower signed range
// Optional feature macro: REFRACTORY_EN widens cfg_sel to 3 bits and adds the
// refractory-steps field encoding.
// -----------------------------------------------------------------------------
package iz_pkg;

`ifdef REFRACTORY_EN
  localparam int CFG_SEL_W = 3;
  localparam int REFR_W    = 4;
`else
  localparam int CFG_SEL_W = 2;
`endif

  localparam logic [CFG_SEL_W-1:0] SEL_A = CFG_SEL_W'(0);
  localparam logic [CFG_SEL_W-1:0] SEL_B = CFG_SEL_W'(1);
  localparam logic [CFG_SEL_W-1:0] SEL_C = CFG_SEL_W'(2);
  localparam logic [CFG_SEL_W-1:0] SEL_D = CFG_SEL_W'(3);
`ifdef REFRACTORY_EN
  localparam logic [CFG_SEL_W-1:0] SEL_R = CFG_SEL_W'(4);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Width used by saturate(); wide enough for any intermediate the datapath builds.
  localparam int SAT_W = 64;

  function automatic int v_thresh(input int frac_bits);
    return 30 * (1 << frac_bits);
  endfunction

  function automatic int v_rest(input int frac_bits);
    return -70 * (1 << frac_bits);
  endfunction

  function automatic int const_140(input int frac_bits);
    return 140 * (1 << frac_bits);
  endfunction

  // Clamp x to [-2^(width-1), 2^(width-1)-1]; caller truncates the result to width.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                       input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/iz_neuron_array_tm_if.sv
// -----------------------------------------------------------------------------
// iz_neuron_array_tm_if
// Handshake bundle between the front end (master) and the neuron array (slave).
//   cfg_valid/cfg_ready/cfg_idx/cfg_sel/cfg_data : per-neuron parameter writes
//   step_valid/step_ready/step_stim               : start-of-step request + stimulus
//   spike_valid/spike_vec                         : completed-step spike report
// cfg_sel is 3 bits wide when REFRACTORY_EN is defined, otherwise 2 bits.
// -----------------------------------------------------------------------------
interface iz_neuron_array_tm_if
  import iz_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int DATA_W    = 16,
  parameter int STIM_W    = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
);
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [IDX_W-1:0]              cfg_idx;
  logic [CFG_SEL_W-1:0]          cfg_sel;
  logic signed [DATA_W-1:0]      cfg_data;
  logic                          step_valid;
  logic                          step_ready;
  logic [N_NEURONS*STIM_W-1:0]   step_stim;
  logic                          spike_valid;
  logic [N_NEURONS-1:0]          spike_vec;

  modport master (
    output cfg_valid, cfg_idx, cfg_sel, cfg_data, step_valid, step_stim,
    input  cfg_ready, step_ready, spike_valid, spike_vec
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_sel, cfg_data, step_valid, step_stim,
    output cfg_ready, step_ready, spike_valid, spike_vec
  );
endinterface

// File: rtl/iz_update_dp.sv
// -----------------------------------------------------------------------------
// iz_update_dp
// Purely combinational one-neuron Izhikevich update in fixed point.
//   v, u          : current state (signed DATA_W)
//   a, b, c, d    : neuron parameters (signed DATA_W)
//   stim          : unsigned stimulus, scaled by 2^FRAC_BITS before use
//   v_next/u_next : saturated next state
//   spike         : v was at or above threshold; reset values chosen instead
// -----------------------------------------------------------------------------
module iz_update_dp
  import iz_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 6,
  parameter int STIM_W    = 8
) (
  input  logic signed [DATA_W-1:0] v,
  input  logic signed [DATA_W-1:0] u,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  input  logic [STIM_W-1:0]        stim,
  output logic signed [DATA_W-1:0] v_next,
  output logic signed [DATA_W-1:0] u_next,
  output logic                     spike
);
  // Headroom for the v*v and b*v products plus the summed terms.
  localparam int IW = 2 * DATA_W + 4;
  localparam logic signed [IW-1:0] V_TH = IW'(v_thresh(FRAC_BITS));
  localparam logic signed [IW-1:0] C140 = IW'(const_140(FRAC_BITS));

  logic signed [IW-1:0] vx, ux, ax, bx, dx, sx;
  logic signed [IW-1:0] vsq, dv, bv_term, du, v_sum, u_sum, u_rst;

  always_comb begin
    vx      = IW'(v);
    ux      = IW'(u);
    ax      = IW'(a);
    bx      = IW'(b);
    dx      = IW'(d);
    sx      = signed'(IW'(stim));
    vsq     = (vx * vx) >>> 10;
    dv      = IW'(3) * vsq + IW'(5) * vx + C140 - ux + (sx <<< FRAC_BITS);
    bv_term = (bx * vx - (ux <<< FRAC_BITS)) >>> FRAC_BITS;
    du      = (ax * bv_term) >>> FRAC_BITS;
    v_sum   = vx + dv;
    u_sum   = ux + du;
    u_rst   = ux + dx;
    spike   = (vx >= V_TH);
    v_next  = spike ? c : DATA_W'(saturate(SAT_W'(v_sum), DATA_W));
    u_next  = DATA_W'(saturate(SAT_W'(spike ? u_rst : u_sum), DATA_W));
  end
endmodule

// File: rtl/iz_neuron_array_tm.sv
// -----------------------------------------------------------------------------
// iz_neuron_array_tm
// N_NEURONS Izhikevich neurons sharing one iz_update_dp. A step visits every
// neuron once (one per cycle), then reports the spike vector for one cycle.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   enable     : run enable; when low the step FSM and neuron index freeze
//   bus        : slave side of iz_neuron_array_tm_if (config, step, spike)
//   mon_idx    : neuron whose v is shown on mon_v
//   mon_v      : registered v of neuron mon_idx (one cycle behind mon_idx)
// Optional feature macro: REFRACTORY_EN adds a per-neuron refractory counter
// and a fifth config field (cfg_sel = 4) holding the refractory step count.
// -----------------------------------------------------------------------------
module iz_neuron_array_tm
  import iz_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 6,
  parameter int STIM_W    = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  iz_neuron_array_tm_if.slave      bus,
  input  logic [IDX_W-1:0]         mon_idx,
  output logic signed [DATA_W-1:0] mon_v
);
  localparam logic signed [DATA_W-1:0] V_RESET  = DATA_W'(v_rest(FRAC_BITS));
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t                      state, state_next;
  logic [IDX_W-1:0]            idx;
  logic [N_NEURONS*STIM_W-1:0] stim_reg;
  logic [N_NEURONS-1:0]        spike_vec_q;
  logic signed [DATA_W-1:0]    v_mem [N_NEURONS];
  logic signed [DATA_W-1:0]    u_mem [N_NEURONS];
  logic signed [DATA_W-1:0]    a_mem [N_NEURONS];
  logic signed [DATA_W-1:0]    b_mem [N_NEURONS];
  logic signed [DATA_W-1:0]    c_mem [N_NEURONS];
  logic signed [DATA_W-1:0]    d_mem [N_NEURONS];
  logic [3:0]                  loaded_mask [N_NEURONS];
`ifdef REFRACTORY_EN
  logic [REFR_W-1:0]           r_mem    [N_NEURONS];
  logic [REFR_W-1:0]           refr_cnt [N_NEURONS];
`endif

  logic                     step_ready_c, spike_valid_c, accept_step, proc_en;
  logic                     cfg_fire, loaded, dp_spike;
  logic signed [DATA_W-1:0] dp_v_next, dp_u_next;

  // Step FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Step FSM: everything holds while enable is low, including the DONE pulse.
  always_comb begin
    state_next    = state;
    step_ready_c  = 1'b0;
    spike_valid_c = 1'b0;
    accept_step   = 1'b0;
    proc_en       = 1'b0;
    case (state)
      IDLE: begin
        step_ready_c = 1'b1;
        if (bus.step_valid && enable) begin
          accept_step = 1'b1;
          state_next  = UPDATE;
        end
      end
      UPDATE: begin
        if (enable) begin
          proc_en = 1'b1;
          if (idx == LAST_IDX) state_next = DONE;
        end
      end
      DONE: begin
        if (enable) begin
          spike_valid_c = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A step request on the same cycle wins over a config write.
  assign bus.step_ready  = step_ready_c;
  assign bus.cfg_ready   = (state == IDLE) && !bus.step_valid && !reset;
  assign bus.spike_valid = spike_valid_c && !reset;
  assign bus.spike_vec   = spike_vec_q;
  assign cfg_fire        = bus.cfg_valid && bus.cfg_ready;
  assign loaded          = &loaded_mask[idx];

  iz_update_dp #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .STIM_W    (STIM_W)
  ) u_dp (
    .v      (v_mem[idx]),
    .u      (u_mem[idx]),
    .a      (a_mem[idx]),
    .b      (b_mem[idx]),
    .c      (c_mem[idx]),
    .d      (d_mem[idx]),
    .stim   (stim_reg[idx*STIM_W +: STIM_W]),
    .v_next (dp_v_next),
    .u_next (dp_u_next),
    .spike  (dp_spike)
  );

  // Neuron state, parameters and monitor. Unloaded neurons keep their state
  // and never spike; config writes only happen in IDLE so never collide with
  // a neuron update.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      stim_reg    <= '0;
      spike_vec_q <= '0;
      mon_v       <= V_RESET;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]       <= V_RESET;
        u_mem[i]       <= '0;
        a_mem[i]       <= '0;
        b_mem[i]       <= '0;
        c_mem[i]       <= '0;
        d_mem[i]       <= '0;
        loaded_mask[i] <= '0;
`ifdef REFRACTORY_EN
        r_mem[i]       <= '0;
        refr_cnt[i]    <= '0;
`endif
      end
    end else begin
      mon_v <= v_mem[mon_idx];

      if (accept_step) begin
        stim_reg <= bus.step_stim;
        idx      <= '0;
      end

      if (proc_en) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        if (!loaded) begin
          spike_vec_q[idx] <= 1'b0;
        end
`ifdef REFRACTORY_EN
        else if (refr_cnt[idx] != '0) begin
          v_mem[idx]       <= c_mem[idx];
          refr_cnt[idx]    <= refr_cnt[idx] - REFR_W'(1);
          spike_vec_q[idx] <= 1'b0;
        end
`endif
        else begin
          v_mem[idx]       <= dp_v_next;
          u_mem[idx]       <= dp_u_next;
          spike_vec_q[idx] <= dp_spike;
`ifdef REFRACTORY_EN
          if (dp_spike) refr_cnt[idx] <= r_mem[idx];
`endif
        end
      end

      if (cfg_fire) begin
        case (bus.cfg_sel)
          SEL_A:   a_mem[bus.cfg_idx] <= bus.cfg_data;
          SEL_B:   b_mem[bus.cfg_idx] <= bus.cfg_data;
          SEL_C:   c_mem[bus.cfg_idx] <= bus.cfg_data;
          SEL_D:   d_mem[bus.cfg_idx] <= bus.cfg_data;
`ifdef REFRACTORY_EN
          SEL_R:   r_mem[bus.cfg_idx] <= bus.cfg_data[REFR_W-1:0];
`endif
          default: ;
        endcase
`ifdef REFRACTORY_EN
        if (bus.cfg_sel != SEL_R)
          loaded_mask[bus.cfg_idx][bus.cfg_sel[1:0]] <= 1'b1;
`else
        loaded_mask[bus.cfg_idx][bus.cfg_sel] <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: doc/iz_neuron_array_tm.md
Name: iz_neuron_array_tm

Overview:
- Time-multiplexed array of N_NEURONS Izhikevich neurons sharing one arithmetic datapath.
- Per-neuron a/b/c/d parameters are written through a valid/ready config port; per-neuron v/u state is held in internal register arrays.
- One "step" integrates every neuron once, then emits a spike vector.
- Sits between the stimulus/data-loader front end and the spike-routing logic; supersedes the single-neuron core.

Parameters:
- N_NEURONS, 4, neuron count (≥2).
- DATA_W, 16, signed width of v, u, a, b, c, d.
- FRAC_BITS, 6, fixed-point fraction bits (S = 2^FRAC_BITS).
- STIM_W, 8, unsigned per-neuron stimulus width.
- IDX_W, $clog2(N_NEURONS), neuron index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global run enable; when low, FSM holds in its current state
- cfg_valid  in  1  parameter write request
- cfg_ready  out  1  write accepted when valid&ready
- cfg_idx  in  IDX_W  target neuron
- cfg_sel  in  2  0=a, 1=b, 2=c, 3=d
- cfg_data  in  DATA_W  parameter value (signed)
- step_valid  in  1  start-of-step request
- step_ready  out  1  high only in IDLE
- step_stim  in  N_NEURONS*STIM_W  stimulus vector, neuron i at [i*STIM_W +: STIM_W]
- spike_valid  out  1  one-cycle pulse at step completion
- spike_vec  out  N_NEURONS  spike flags for the completed step
- mon_idx  in  IDX_W  monitor select
- mon_v  out  DATA_W  registered v of neuron mon_idx

Behaviour:
- Reset values:
  - every v = -70*S; every u = 0; all params 0; loaded[i] = 0.
  - FSM = IDLE; spike_vec = 0; spike_valid = 0; cfg_ready = 0; mon_v = -70*S.
- FSM:
  - IDLE: step_ready=1. On step_valid&enable, latch step_stim, set idx=0, go UPDATE.
  - UPDATE: process neuron idx each cycle; after idx = N_NEURONS-1, go DONE.
  - DONE: spike_valid=1 for one cycle with the full spike_vec, then go IDLE.
- Latency: step accepted at cycle T; neurons processed T+1..T+N; spike_valid at T+N+1. Next step can be accepted at T+N+2.
- Config:
  - cfg_ready = IDLE & ~step_valid (a step has priority on the same cycle).
  - A write updates the selected parameter.
  - loaded[idx] is set once all four fields of that neuron have been written since reset (4-bit mask per neuron).
- Neuron update (combinational from state, registered into arrays):
  - vsq = (v*v)>>>10
  - dv = 3*vsq + 5*v + 140*S - u + stim*S
  - du = (a*((b*v - (u<<<FRAC_BITS))>>>FRAC_BITS))>>>FRAC_BITS
  - Intermediates use 2*DATA_W+4 bits.
  - Updates are saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; no wrap.
- Spike: if v ≥ 30*S at process time, then v←c, u←sat(u+d), spike_vec[idx]=1. Otherwise v←sat(v+dv), u←sat(u+du), spike_vec[idx]=0.
- Unloaded neuron (loaded=0): state is held and its spike bit is forced to 0.
- enable low mid-UPDATE: idx and state are frozen; processing resumes at the same idx when enable returns.
- Reset mid-step: abort immediately to reset values; no spike_valid is issued.
- mon_v updates every cycle from the v array (one-cycle latency).

Optional Feature:
- REFRACTORY_EN:
  - Defined: adds a per-neuron 4-bit refractory counter and a fifth config field, cfg_sel width 3 with value 4 = refractory steps R.
  - After a spike, the next R steps hold v=c and u unchanged, ignore stimulus, and force the spike bit to 0. The counter decrements once per step.
  - loaded[i] still requires only a/b/c/d; R resets to 0.
- Undefined: no counter; cfg_sel is 2 bits; behaviour as above.

Decomposition:
- Package iz_pkg holds:
  - scale constants V_THRESH, V_REST, CONST_140 as functions of FRAC_BITS;
  - the cfg_sel encodings;
  - the FSM state enum;
  - the saturate function.
- Sub-module iz_update_dp: purely combinational one-neuron datapath (v, u, a, b, c, d, stim → v_next, u_next, spike).

Test Plan:
- Reset, then step_valid with no config → spike_valid at T+5 (N=4), spike_vec=0, all v = -4480.
- Load neuron 0 with a=1, b=12, c=-4160, d=512; stim0=10, others 0; run steps → neuron 0 spike_vec[0] pulses, v returns to -4160; neurons 1-3 stay at -4480.
- Issue step_valid and cfg_valid on the same cycle → step accepted, cfg_ready=0; config accepted after spike_valid.
- Drive stim=255 with a=0 repeatedly → v saturates to 32767, never wraps negative, and spikes.
- Deassert enable for 3 cycles mid-UPDATE → spike_valid is delayed by exactly 3 cycles, with results identical to the uninterrupted run.
- REFRACTORY_EN, R=2 → after a spike, the next two steps report no spike and v=c, even with stim=255.
